// File: rtl/codec_pkg.sv
// rtl/codec_pkg.sv - shared frame timing constants and FSM state type for the codec transmitter
package codec_pkg;

    localparam int FRAME_CLKS = 1024;
    localparam int SCLK_DIV   = 32;
    localparam int MCLK_DIV   = 4;

    localparam int CNT_W      = $clog2(FRAME_CLKS);
    localparam int SCLK_BITS  = $clog2(SCLK_DIV);
    localparam int MCLK_BITS  = $clog2(MCLK_DIV);

    localparam logic [CNT_W-1:0] LOAD_POS  = CNT_W'(31);
    localparam logic [CNT_W-1:0] VALID_POS = CNT_W'(FRAME_CLKS - 1);

    typedef enum logic [1:0] {
        ST_RST,
        ST_SYNC,
        ST_RUN
    } state_t;

endpackage

// File: rtl/codec_xmtr_if.sv
// rtl/codec_xmtr_if.sv - sample handshake between effect core and codec transmitter
interface codec_xmtr_if;

    logic [15:0] lft_in;
    logic [15:0] rht_in;
    logic        VALID;

    // Effect core drives samples and advances on the frame strobe
    modport master (output lft_in, output rht_in, input VALID);
    // Transmitter consumes samples and issues the frame strobe
    modport slave  (input lft_in, input rht_in, output VALID);

endinterface

// File: rtl/codec_clk_gen.sv
// rtl/codec_clk_gen.sv - frame counter and glitch-free codec clock derivation
module codec_clk_gen
    import codec_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en_i,
    output logic [CNT_W-1:0] cnt_o,
    output logic             MCLK,
    output logic             SCLK,
    output logic             LRCLK
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign cnt_d = en_i ? cnt_q + 1'b1 : '0;

    // Frame counter free-runs (natural wrap) when enabled, parked at zero otherwise
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Codec clocks are plain flop bits so they never glitch
    assign MCLK  = cnt_q[MCLK_BITS-1];
    assign SCLK  = cnt_q[SCLK_BITS-1];
    assign LRCLK = cnt_q[CNT_W-1];
    assign cnt_o = cnt_q;

endmodule

// File: rtl/codec_xmtr.sv
// rtl/codec_xmtr.sv - I2S transmitter: codec reset sequencing, frame strobe and serial shifter
module codec_xmtr
    import codec_pkg::*;
#(
    parameter int RST_CYCLES = 4096
) (
    input  logic         clk,
    input  logic         rst_n,
    codec_xmtr_if.slave  core,
    output logic         MCLK,
    output logic         SCLK,
    output logic         LRCLK,
    output logic         SDout,
    output logic         codec_rst_n
);

    localparam int               WAIT_W    = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0]  PRE_VALID = VALID_POS - 1'b1;

    state_t            state_q;
    logic [WAIT_W-1:0] wait_q;
    logic              valid_q;
    logic              codec_rst_n_q;
    logic [31:0]       sr_q;
    logic [CNT_W-1:0]  cnt;
    logic              cnt_en;
    logic              sclk_fall;

    // Counter only runs once the codec has been released from reset
    assign cnt_en = (state_q != ST_RST);

    codec_clk_gen u_clk_gen (
        .clk   (clk),
        .rst_n (rst_n),
        .en_i  (cnt_en),
        .cnt_o (cnt),
        .MCLK  (MCLK),
        .SCLK  (SCLK),
        .LRCLK (LRCLK)
    );

    // Hold codec in reset, wait one silent frame to align, then stream forever
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= ST_RST;
            wait_q        <= '0;
            codec_rst_n_q <= 1'b0;
            valid_q       <= 1'b0;
        end else begin
            case (state_q)
                ST_RST: begin
                    if (wait_q == WAIT_LAST) begin
                        state_q       <= ST_SYNC;
                        codec_rst_n_q <= 1'b1;
                    end else begin
                        wait_q <= wait_q + 1'b1;
                    end
                end
                ST_SYNC: begin
                    if (cnt == VALID_POS) begin
                        state_q <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    state_q <= ST_RUN;
                end
                default: begin
                    state_q <= ST_RST;
                end
            endcase
            // Registered one cycle early so the strobe lands on the last count of the frame
            valid_q <= (state_q == ST_RUN) && (cnt == PRE_VALID);
        end
    end

    // SCLK falls on the edge leaving the last count of each bit period
    assign sclk_fall = (cnt[SCLK_BITS-1:0] == '1);

    // Load the sample pair once per frame, otherwise shift MSB-first on SCLK falling
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sr_q <= '0;
        end else if (state_q == ST_RUN && sclk_fall) begin
            if (cnt == LOAD_POS) begin
                sr_q <= {core.lft_in, core.rht_in};
            end else begin
                sr_q <= {sr_q[30:0], 1'b0};
            end
        end
    end

    assign SDout       = sr_q[31];
    assign codec_rst_n = codec_rst_n_q;
    assign core.VALID  = valid_q;

endmodule

// File: tb/tb_codec_xmtr.sv
// tb/tb_codec_xmtr.sv - scoreboard bench for codec_xmtr with a time-based I2S reference model
module tb_codec_xmtr;
    import codec_pkg::*;

    localparam int RST = 16;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic MCLK, SCLK, LRCLK, SDout, codec_rst_n;

    codec_xmtr_if bus ();

    codec_xmtr #(.RST_CYCLES(RST)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .core        (bus),
        .MCLK        (MCLK),
        .SCLK        (SCLK),
        .LRCLK       (LRCLK),
        .SDout       (SDout),
        .codec_rst_n (codec_rst_n)
    );

    always #10 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    bit armed  = 0;
    bit exp_q[$];
    int valid_seen = 0;
    int valid_exp  = 0;
    logic prev_sclk = 1'b0;
    logic prev_sd   = 1'b0;

    // cyc = clock edges with rst_n high since the last edge that saw rst_n low
    function automatic int frame_pos(int c);
        return (c >= RST) ? (c - RST) % FRAME_CLKS : 0;
    endfunction

    function automatic bit running(int c);
        return c >= RST + FRAME_CLKS;
    endfunction

    function automatic int run_frame(int c);
        return (c - RST) / FRAME_CLKS - 1;
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d actual=%h expected=%h", name, cyc, act, exp);
        end
    endtask

    always @(posedge clk) begin
        if (!rst_n) begin
            cyc   <= 0;
            armed <= 1'b1;
            exp_q.delete();
        end else begin
            cyc <= cyc + 1;
        end
    end

    task automatic drive(int c);
        logic [15:0] l, r;
        int p, f;
        p = frame_pos(c);
        f = running(c) ? run_frame(c) : -1;
        case (f)
            0:       begin l = 16'hA5C3; r = 16'h3C5A; end
            1:       begin l = 16'h8000; r = 16'h0001; end
            2:       begin l = (p < 500) ? 16'h0000 : 16'hFFFF; r = 16'h0000; end
            3:       begin l = 16'hFFFF; r = 16'h0000; end
            default: begin l = 16'($urandom); r = 16'($urandom); end
        endcase
        bus.lft_in = l;
        bus.rht_in = r;
        if (running(c) && p == 31) begin
            for (int i = 15; i >= 0; i--) exp_q.push_back(l[i]);
            for (int i = 15; i >= 0; i--) exp_q.push_back(r[i]);
        end
    endtask

    always @(negedge clk) begin : monitor
        int p;
        bit run;
        bit e;
        if (armed) begin
            p   = frame_pos(cyc);
            run = running(cyc);
            check("codec_rst_n", codec_rst_n, cyc >= RST);
            check("MCLK", MCLK, p[1]);
            check("SCLK", SCLK, p[4]);
            check("LRCLK", LRCLK, p[9]);
            check("VALID", bus.VALID, run && p == FRAME_CLKS - 1);
            if (bus.VALID === 1'b1) valid_seen++;
            if (run && p == FRAME_CLKS - 1) valid_exp++;
            if (cyc < RST + FRAME_CLKS + 32) check("SDout_idle", SDout, 0);
            if (SDout !== prev_sd) check("SDout_edge_pos", p % 32, 0);
            if (SCLK === 1'b1 && prev_sclk === 1'b0) begin
                e = (exp_q.size() > 0) ? exp_q.pop_front() : 1'b0;
                check("SDout_bit", SDout, e);
            end
            prev_sclk = SCLK;
            prev_sd   = SDout;
        end
    end

    initial begin
        int phase;
        phase = 0;
        bus.lft_in = '0;
        bus.rht_in = '0;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        for (int n = 0; n < 40000; n++) begin
            @(posedge clk);
            #1;
            rst_n = 1'b1;
            if (phase == 1 && cyc >= RST + 4 * FRAME_CLKS) break;
            if (phase == 0 && running(cyc) && run_frame(cyc) == 10 && frame_pos(cyc) == 700) begin
                rst_n = 1'b0;
                phase = 1;
            end
            drive(cyc);
        end
        check("reached_end", phase, 1);
        check("valid_count", valid_seen, valid_exp);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
